sample_pingpong_buffer: RTL

//   Dual-bank (ping-pong) input sample store that feeds the 128-tap DA engine.

---
 rtl/fir_pkg.sv | 15 +
 rtl/sample_bank_ram.sv | 34 +++
 rtl/sample_pingpong_buffer.sv | 97 +++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared sizing and write-FSM encoding for the sample ping-pong buffer.
package fir_pkg;

  localparam int unsigned TAPS   = 128;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = $clog2(TAPS);

  localparam logic [7:0] DropMax = 8'hFF;

  typedef enum logic {
    StFill = 1'b0,
    StFull = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sample_bank_ram.sv
// Two banks of samples in one simple dual-port RAM; bank chosen by the address MSB.
module sample_bank_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem [Depth];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_pingpong_buffer.sv
// Ping-pong sample store: fills one bank while the DA engine reads the other.
module sample_pingpong_buffer
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = fir_pkg::TAPS,
  parameter int unsigned DATA_W = fir_pkg::DATA_W,
  parameter int unsigned ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              swap_req,
  output logic              buffer_ready,
  output logic              bank_sel,
  output logic [ADDR_W:0]   fill_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        drop_count
);

  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(TAPS - 1);
  localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);

  wr_state_e state;

  logic            wr_en;
  logic [ADDR_W:0] wr_addr;
  logic [ADDR_W:0] rd_addr_full;

  always_comb begin
    wr_en        = in_valid && (state == StFill) && !flush;
    wr_addr      = {bank_sel, fill_count[ADDR_W-1:0]};
    rd_addr_full = {~bank_sel, rd_addr};
  end

  // Priority within a cycle: flush, then swap, then write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StFill;
      in_ready     <= 1'b1;
      buffer_ready <= 1'b0;
      bank_sel     <= 1'b0;
      fill_count   <= '0;
      drop_count   <= '0;
    end else if (flush) begin
      state        <= StFill;
      in_ready     <= 1'b1;
      buffer_ready <= 1'b0;
      bank_sel     <= 1'b0;
      fill_count   <= '0;
      drop_count   <= '0;
    end else begin
      unique case (state)
        StFill: begin
          if (in_valid) begin
            fill_count <= fill_count + CntOne;
            if (fill_count == LastIdx) begin
              state        <= StFull;
              in_ready     <= 1'b0;
              buffer_ready <= 1'b1;
            end
          end
        end
        StFull: begin
          if (in_valid && (drop_count != DropMax)) begin
            drop_count <= drop_count + 8'd1;
          end
          if (swap_req) begin
            state        <= StFill;
            in_ready     <= 1'b1;
            buffer_ready <= 1'b0;
            bank_sel     <= ~bank_sel;
            fill_count   <= '0;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

  sample_bank_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(in_data),
    .rd_addr(rd_addr_full),
    .rd_data(rd_data)
  );

endmodule
